// File: rtl/inst_fetcher.sv
// inst_fetcher: front-end fetch stage feeding the issue queue.
// Holds the PC, issues single-word fetches to the memory controller,
// statically predicts the next PC (JAL/branch taken, JALR stalls until the
// ROB redirects) and pushes {inst, addr} into the issue queue.
// Optional feature macro: ICACHE_EN adds a direct-mapped instruction cache
// with ICACHE_LINES lines, giving 1-cycle pushes on a hit.
module inst_fetcher #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int unsigned ICACHE_LINES = 32
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        _clear,
  input  logic [31:0] _clear_pc,
  input  logic        _need_inst,
  output logic        _mem_req,
  output logic [31:0] _mem_addr,
  input  logic        _mem_resp_valid,
  input  logic [31:0] _mem_resp_data,
  output logic        _inst_ready_out,
  output logic [31:0] _inst_out,
  output logic [31:0] _inst_addr_out
);

  localparam int IDX_W = $clog2(ICACHE_LINES);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_DRAIN  = 2'd2,
    S_JSTALL = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        mem_req_q;
  logic [31:0] mem_addr_q;
  logic        inst_ready_q;
  logic [31:0] inst_q;
  logic [31:0] inst_addr_q;

  logic        cache_hit;
  logic [31:0] cache_data;
  logic [31:0] fetch_word;
  logic [31:0] j_imm;
  logic [31:0] b_imm;
  logic [31:0] pred_pc_d;
  logic        is_jalr;

`ifdef ICACHE_EN
  localparam int TAG_W = 30 - IDX_W;

  logic [TAG_W-1:0]        tag_mem  [ICACHE_LINES];
  logic [31:0]             data_mem [ICACHE_LINES];
  logic [ICACHE_LINES-1:0] valid_q;
  logic [IDX_W-1:0]        rd_idx;
  logic [IDX_W-1:0]        fill_idx;
  logic                    fill_en;

  // Any response to an outstanding request fills its line, including one
  // being drained after a redirect: the address it belongs to is still valid.
  assign fill_en  = rdy_in && !rst_in && _mem_resp_valid &&
                    ((state_q == S_WAIT) || (state_q == S_DRAIN));
  assign fill_idx = mem_addr_q[2 +: IDX_W];
  assign rd_idx   = pc_q[2 +: IDX_W];

  // Lookup is combinational on the current PC so a hit can push next cycle.
  always_comb begin
    cache_hit  = valid_q[rd_idx] && (tag_mem[rd_idx] == pc_q[31:2+IDX_W]);
    cache_data = data_mem[rd_idx];
  end

  // Tag/data storage is written on fill only; no reset needed for contents.
  always_ff @(posedge clk_in) begin
    if (fill_en) begin
      tag_mem[fill_idx]  <= mem_addr_q[31:2+IDX_W];
      data_mem[fill_idx] <= _mem_resp_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ICACHE_LINES; gi++) begin : g_valid
      // Per-line valid bit: cleared only by reset, set when the line fills.
      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          valid_q[gi] <= 1'b0;
        end else if (fill_en && (fill_idx == IDX_W'(gi))) begin
          valid_q[gi] <= 1'b1;
        end
      end
    end
  endgenerate
`else
  logic [IDX_W-1:0] cache_idx_unused;

  assign cache_idx_unused = pc_q[2 +: IDX_W];
  assign cache_hit        = 1'b0;
  assign cache_data       = 32'h0;
`endif

  // The word being pushed comes from memory in WAIT, from the cache in IDLE.
  assign fetch_word = (state_q == S_WAIT) ? _mem_resp_data : cache_data;

  // Static next-PC predictor: JAL and branches taken, JALR stalls.
  always_comb begin
    j_imm     = {{12{fetch_word[31]}}, fetch_word[19:12], fetch_word[20],
                 fetch_word[30:21], 1'b0};
    b_imm     = {{20{fetch_word[31]}}, fetch_word[7], fetch_word[30:25],
                 fetch_word[11:8], 1'b0};
    pred_pc_d = pc_q + 32'd4;
    is_jalr   = 1'b0;
    case (fetch_word[6:0])
      OP_JAL:    pred_pc_d = pc_q + j_imm;
      OP_BRANCH: pred_pc_d = pc_q + b_imm;
      OP_JALR:   is_jalr   = 1'b1;
      default:   ;
    endcase
  end

  // Fetch FSM with registered memory-request and push outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 32'h0;
      inst_ready_q <= 1'b0;
      inst_q       <= 32'h0;
      inst_addr_q  <= 32'h0;
    end else if (rdy_in) begin
      inst_ready_q <= 1'b0;
      if (_clear) begin
        // Redirect wins over any push; an in-flight request must still
        // complete, so WAIT without a response drains it first.
        pc_q <= _clear_pc;
        case (state_q)
          S_WAIT: begin
            if (_mem_resp_valid) begin
              mem_req_q <= 1'b0;
              state_q   <= S_IDLE;
            end else begin
              state_q   <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (_mem_resp_valid) begin
              mem_req_q <= 1'b0;
              state_q   <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end else begin
        case (state_q)
          S_IDLE: begin
            if (_need_inst) begin
              if (cache_hit) begin
                inst_ready_q <= 1'b1;
                inst_q       <= fetch_word;
                inst_addr_q  <= pc_q;
                pc_q         <= pred_pc_d;
                state_q      <= is_jalr ? S_JSTALL : S_IDLE;
              end else begin
                mem_req_q  <= 1'b1;
                mem_addr_q <= pc_q;
                state_q    <= S_WAIT;
              end
            end
          end
          S_WAIT: begin
            if (_mem_resp_valid) begin
              mem_req_q    <= 1'b0;
              inst_ready_q <= 1'b1;
              inst_q       <= fetch_word;
              inst_addr_q  <= pc_q;
              pc_q         <= pred_pc_d;
              state_q      <= is_jalr ? S_JSTALL : S_IDLE;
            end
          end
          S_DRAIN: begin
            if (_mem_resp_valid) begin
              mem_req_q <= 1'b0;
              state_q   <= S_IDLE;
            end
          end
          default: ;  // JSTALL waits for a redirect
        endcase
      end
    end
  end

  assign _mem_req        = mem_req_q;
  assign _mem_addr       = mem_addr_q;
  assign _inst_ready_out = inst_ready_q;
  assign _inst_out       = inst_q;
  assign _inst_addr_out  = inst_addr_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed testbench for inst_fetcher with a fixed-latency memory model.
module tb_inst_fetcher;

  localparam int LAT = 3;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        _clear = 1'b0;
  logic [31:0] _clear_pc = 32'h0;
  logic        _need_inst = 1'b0;
  logic        _mem_req;
  logic [31:0] _mem_addr;
  logic        _mem_resp_valid = 1'b0;
  logic [31:0] _mem_resp_data = 32'h0;
  logic        _inst_ready_out;
  logic [31:0] _inst_out;
  logic [31:0] _inst_addr_out;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [31:0] imem [logic [31:0]];
  logic [31:0] req_q[$];
  logic [31:0] push_addr_q[$];
  logic [31:0] push_inst_q[$];
  int          push_cyc_q[$];
  int          resp_cyc_q[$];

  inst_fetcher #(.RESET_PC(32'h0), .ICACHE_LINES(32)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    ._clear          (_clear),
    ._clear_pc       (_clear_pc),
    ._need_inst      (_need_inst),
    ._mem_req        (_mem_req),
    ._mem_addr       (_mem_addr),
    ._mem_resp_valid (_mem_resp_valid),
    ._mem_resp_data  (_mem_resp_data),
    ._inst_ready_out (_inst_ready_out),
    ._inst_out       (_inst_out),
    ._inst_addr_out  (_inst_addr_out)
  );

  initial forever #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc++;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (imem.exists(a)) return imem[a];
    return 32'h00000013;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Memory controller model: answers LAT cycles after a request, frozen by rdy_in.
  initial begin
    bit          busy = 0;
    int          cnt = 0;
    logic [31:0] req_addr = 32'h0;
    forever begin
      @(posedge clk_in); #1;
      if (rst_in) begin
        busy = 0; cnt = 0; _mem_resp_valid = 1'b0;
      end else if (rdy_in) begin
        if (_mem_resp_valid) begin
          _mem_resp_valid = 1'b0;
          busy = 0;
          resp_cyc_q.push_back(cyc);
        end
        if (!busy) begin
          if (_mem_req) begin
            busy = 1; cnt = 0; req_addr = _mem_addr;
            req_q.push_back(_mem_addr);
          end
        end else begin
          cnt++;
          if (cnt == LAT) begin
            _mem_resp_valid = 1'b1;
            _mem_resp_data  = mem_word(req_addr);
          end
        end
      end
    end
  end

  // Push monitor: records each strobe the issue queue would accept.
  initial forever begin
    @(negedge clk_in); #2;
    if (rdy_in && !rst_in && _inst_ready_out) begin
      push_addr_q.push_back(_inst_addr_out);
      push_inst_q.push_back(_inst_out);
      push_cyc_q.push_back(cyc);
      $display("push  addr=%08h inst=%08h cyc=%0d", _inst_addr_out, _inst_out, cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1; rdy_in = 1'b1; _clear = 1'b0; _need_inst = 1'b0;
    tick(2);
    check("rst_mem_req", {31'h0, _mem_req}, 32'h0);
    check("rst_strobe", {31'h0, _inst_ready_out}, 32'h0);
    rst_in = 1'b0;
    req_q.delete(); push_addr_q.delete(); push_inst_q.delete();
    push_cyc_q.delete(); resp_cyc_q.delete();
  endtask

  task automatic redirect(input logic [31:0] a);
    @(negedge clk_in);
    _clear = 1'b1; _clear_pc = a;
    @(negedge clk_in);
    _clear = 1'b0;
  endtask

  task automatic wait_pushes(input string tag, input int n);
    int k = 0;
    while (push_addr_q.size() < n && k < 300) begin
      tick(1); k++;
    end
    tick(1);
    check(tag, 32'(push_addr_q.size() >= n), 32'h1);
  endtask

  task automatic wait_reqs(input string tag, input int n);
    int k = 0;
    while (req_q.size() < n && k < 300) begin
      tick(1); k++;
    end
    check(tag, 32'(req_q.size() >= n), 32'h1);
  endtask

  initial begin
    // Reset values
    tick(2);
    check("rst_mem_addr", _mem_addr, 32'h0);
    check("rst_inst", _inst_out, 32'h0);
    check("rst_inst_addr", _inst_addr_out, 32'h0);

    // Sequential nops from RESET_PC
    do_reset();
    _need_inst = 1'b1;
    wait_pushes("seq_wait", 3);
    check("seq_addr0", push_addr_q[0], 32'h0);
    check("seq_addr1", push_addr_q[1], 32'h4);
    check("seq_addr2", push_addr_q[2], 32'h8);
    check("seq_inst0", push_inst_q[0], 32'h13);
    check("seq_inst2", push_inst_q[2], 32'h13);
    check("seq_req1", req_q[1], 32'h4);
    check("seq_latency", 32'(push_cyc_q[0]), 32'(resp_cyc_q[0]));

    // JAL +16 at 0x100
    imem[32'h100] = 32'h0100006F;
    do_reset();
    redirect(32'h100);
    _need_inst = 1'b1;
    wait_pushes("jal_wait", 2);
    check("jal_addr", push_addr_q[0], 32'h100);
    check("jal_inst", push_inst_q[0], 32'h0100006F);
    check("jal_req", req_q[1], 32'h110);
    check("jal_next", push_addr_q[1], 32'h110);

    // BEQ -8 at 0x20
    imem[32'h20] = 32'hFE000CE3;
    do_reset();
    redirect(32'h20);
    _need_inst = 1'b1;
    wait_pushes("beq_wait", 2);
    check("beq_addr", push_addr_q[0], 32'h20);
    check("beq_req", req_q[1], 32'h18);

    // JALR at 0x40 stalls until redirected to 0x80
    imem[32'h40] = 32'h00008067;
    do_reset();
    redirect(32'h40);
    _need_inst = 1'b1;
    wait_pushes("jalr_wait", 1);
    tick(12);
    check("jalr_push", push_addr_q[0], 32'h40);
    check("jalr_nreq", 32'(req_q.size()), 32'd1);
    check("jalr_npush", 32'(push_addr_q.size()), 32'd1);
    check("jalr_mem_req", {31'h0, _mem_req}, 32'h0);
    redirect(32'h80);
    wait_pushes("jalr_redir_wait", 2);
    check("jalr_redir_req", req_q[1], 32'h80);
    check("jalr_redir_push", push_addr_q[1], 32'h80);

    // Clear while waiting, no response in the same cycle
    do_reset();
    redirect(32'h30);
    _need_inst = 1'b1;
    wait_reqs("drain_req_wait", 1);
    redirect(32'h200);
    wait_pushes("drain_wait", 1);
    check("drain_req0", req_q[0], 32'h30);
    check("drain_req1", req_q[1], 32'h200);
    check("drain_push", push_addr_q[0], 32'h200);

    // Clear in the same cycle as the response
    do_reset();
    redirect(32'h30);
    _need_inst = 1'b1;
    begin
      int k = 0;
      while (!_mem_resp_valid && k < 50) begin tick(1); k++; end
      check("same_resp_seen", {31'h0, _mem_resp_valid}, 32'h1);
    end
    _clear = 1'b1; _clear_pc = 32'h300;
    tick(1);
    _clear = 1'b0;
    wait_pushes("same_wait", 1);
    check("same_push", push_addr_q[0], 32'h300);

    // _need_inst low keeps the fetcher idle
    do_reset();
    tick(10);
    check("idle_mem_req", {31'h0, _mem_req}, 32'h0);
    check("idle_nreq", 32'(req_q.size()), 32'd0);

    // rdy_in low for 5 cycles mid-WAIT
    do_reset();
    _need_inst = 1'b1;
    wait_reqs("frz_req_wait", 1);
    tick(1);
    rdy_in = 1'b0;
    tick(5);
    check("frz_mem_req", {31'h0, _mem_req}, 32'h1);
    check("frz_mem_addr", _mem_addr, 32'h0);
    check("frz_strobe", {31'h0, _inst_ready_out}, 32'h0);
    check("frz_npush", 32'(push_addr_q.size()), 32'd0);
    rdy_in = 1'b1;
    wait_pushes("frz_wait", 3);
    check("frz_addr0", push_addr_q[0], 32'h0);
    check("frz_addr2", push_addr_q[2], 32'h8);

    // PC wrap
    do_reset();
    redirect(32'hFFFFFFFC);
    _need_inst = 1'b1;
    wait_pushes("wrap_wait", 2);
    check("wrap_addr0", push_addr_q[0], 32'hFFFFFFFC);
    check("wrap_addr1", push_addr_q[1], 32'h0);

`ifdef ICACHE_EN
    // Loop 0x0..0xC twice: second pass served from the cache
    imem[32'hC] = 32'hFF5FF06F;
    do_reset();
    _need_inst = 1'b1;
    wait_pushes("loop_wait", 8);
    check("loop_nreq", 32'(req_q.size()), 32'd4);
    check("loop_addr3", push_addr_q[3], 32'hC);
    check("loop_addr4", push_addr_q[4], 32'h0);
    check("loop_addr7", push_addr_q[7], 32'hC);
    check("loop_rate", 32'(push_cyc_q[7] - push_cyc_q[4]), 32'd3);
`endif

    _need_inst = 1'b0;
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
